// File: rtl/amm_perf_monitor.sv
// Passive Avalon-MM monitor: read-burst latency min/max/sum, throughput counters, sticky protocol errors.
// Define MEAS_HISTOGRAM_EN to add saturating latency histogram bins readable through hist_sel_i/hist_cnt_o.
module amm_perf_monitor #(
  parameter int    AMM_BURST_W = 11,
  parameter int    DATA_B_W    = 8,
  parameter int    MAX_OUTST   = 8,
  parameter int    DELAY_W     = 16,
  parameter string ADDR_TYPE   = "BYTE",
  parameter int    HIST_BINS   = 8,
  parameter int    HIST_SHIFT  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         readdatavalid_i,
  input  logic                         waitrequest_i,
  input  logic                         read_i,
  input  logic                         write_i,
  input  logic [AMM_BURST_W-1:0]       burstcount_i,
  input  logic [DATA_B_W-1:0]          byteenable_i,
  input  logic                         start_test_i,
  output logic                         meas_busy_o,
  output logic [31:0]                  wr_ticks_o,
  output logic [31:0]                  wr_units_o,
  output logic [31:0]                  rd_ticks_o,
  output logic [31:0]                  rd_words_o,
  output logic [31:0]                  rd_req_amount_o,
  output logic [2*DELAY_W-1:0]         min_max_delay_o,
  output logic [31:0]                  sum_delay_o,
  output logic [1:0]                   err_o,
  input  logic [$clog2(HIST_BINS)-1:0] hist_sel_i,
  output logic [31:0]                  hist_cnt_o
);

  localparam int PTR_W     = $clog2(MAX_OUTST);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PC_W      = $clog2(DATA_B_W + 1);
  localparam int HB_W      = $clog2(HIST_BINS);
  localparam bit BYTE_MODE = (ADDR_TYPE == "BYTE");

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_B_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_B_W; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  logic [AMM_BURST_W-1:0] beats_q [MAX_OUTST];
  logic [AMM_BURST_W-1:0] beats_d [MAX_OUTST];
  logic [DELAY_W-1:0]     delay_q [MAX_OUTST];
  logic [DELAY_W-1:0]     delay_d [MAX_OUTST];
  logic [MAX_OUTST-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [DELAY_W-1:0]     s1_lat_q, s1_lat_d;
  logic [DELAY_W-1:0]     min_q, min_d, max_q, max_d;
  logic [31:0]            sum_q, sum_d, req_q, req_d;
  logic [31:0]            wr_ticks_q, wr_ticks_d, wr_units_q, wr_units_d;
  logic [31:0]            rd_ticks_q, rd_ticks_d, rd_words_q, rd_words_d;
  logic [PC_W-1:0]        wu_add_q, wu_add_d;
  logic [1:0]             err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   rd_acc, wr_acc, full, empty, push, beat_hit, pop;
  logic [DELAY_W-1:0]     head_lat;

  // Head slot absorbs data beats; its last beat pops and yields the saturated latency.
  always_comb begin
    rd_acc   = read_i && !waitrequest_i;
    wr_acc   = write_i && !waitrequest_i;
    full     = (count_q == CNT_W'(MAX_OUTST));
    empty    = (count_q == '0);
    push     = rd_acc && !full;
    beat_hit = readdatavalid_i && !empty;
    pop      = beat_hit && (beats_q[rd_ptr_q] == AMM_BURST_W'(1));
    head_lat = (delay_q[rd_ptr_q] == '1) ? delay_q[rd_ptr_q] : delay_q[rd_ptr_q] + DELAY_W'(1);
    valid_d  = valid_q;
    for (int i = 0; i < MAX_OUTST; i++) begin
      beats_d[i] = beats_q[i];
      delay_d[i] = (valid_q[i] && delay_q[i] != '1) ? delay_q[i] + DELAY_W'(1) : delay_q[i];
    end
    if (beat_hit) begin
      beats_d[rd_ptr_q] = beats_q[rd_ptr_q] - AMM_BURST_W'(1);
      if (pop) valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      beats_d[wr_ptr_q] = burstcount_i;
      delay_d[wr_ptr_q] = '0;
      valid_d[wr_ptr_q] = 1'b1;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    s1_valid_d = pop;
    s1_lat_d   = pop ? head_lat : s1_lat_q;
    busy_d     = !empty || s1_valid_q;
    wu_add_d   = wr_acc ? popcount(byteenable_i) : '0;
    wr_ticks_d = sat_add(wr_ticks_q, 32'(write_i));
    wr_units_d = sat_add(wr_units_q, BYTE_MODE ? 32'(wu_add_q) : 32'(wr_acc));
    rd_ticks_d = sat_add(rd_ticks_q, 32'(!empty));
    rd_words_d = sat_add(rd_words_q, 32'(readdatavalid_i));
    err_d      = err_q | {readdatavalid_i && empty, rd_acc && full};
    min_d      = min_q;
    max_d      = max_q;
    sum_d      = sum_q;
    req_d      = req_q;
    if (s1_valid_q) begin
      if (s1_lat_q < min_q) min_d = s1_lat_q;
      if (s1_lat_q > max_q) max_d = s1_lat_q;
      sum_d = sat_add(sum_q, 32'(s1_lat_q));
      req_d = sat_add(req_q, 32'd1);
    end
    // Clear wins over anything that would have landed this cycle; tracker keeps running.
    if (start_test_i) begin
      min_d      = '1;
      max_d      = '0;
      sum_d      = '0;
      req_d      = '0;
      wr_ticks_d = '0;
      wr_units_d = '0;
      rd_ticks_d = '0;
      rd_words_d = '0;
      err_d      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        beats_q[i] <= '0;
        delay_q[i] <= '0;
      end
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_lat_q   <= '0;
      min_q      <= '1;
      max_q      <= '0;
      sum_q      <= '0;
      req_q      <= '0;
      wr_ticks_q <= '0;
      wr_units_q <= '0;
      rd_ticks_q <= '0;
      rd_words_q <= '0;
      wu_add_q   <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      beats_q    <= beats_d;
      delay_q    <= delay_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s1_valid_q <= s1_valid_d;
      s1_lat_q   <= s1_lat_d;
      min_q      <= min_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      req_q      <= req_d;
      wr_ticks_q <= wr_ticks_d;
      wr_units_q <= wr_units_d;
      rd_ticks_q <= rd_ticks_d;
      rd_words_q <= rd_words_d;
      wu_add_q   <= wu_add_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

`ifdef MEAS_HISTOGRAM_EN
  logic [31:0]        hist_q [HIST_BINS];
  logic [31:0]        hist_d [HIST_BINS];
  logic [31:0]        hist_cnt_q, hist_cnt_d;
  logic [DELAY_W-1:0] bin_raw;
  logic [HB_W-1:0]    bin_idx;

  // Latencies beyond the last bin's range all pile into the top bin.
  always_comb begin
    bin_raw    = s1_lat_q >> HIST_SHIFT;
    bin_idx    = (bin_raw > DELAY_W'(HIST_BINS - 1)) ? HB_W'(HIST_BINS - 1) : bin_raw[HB_W-1:0];
    hist_cnt_d = hist_q[hist_sel_i];
    hist_d     = hist_q;
    if (start_test_i) begin
      for (int i = 0; i < HIST_BINS; i++) hist_d[i] = '0;
    end else if (s1_valid_q) begin
      hist_d[bin_idx] = sat_add(hist_q[bin_idx], 32'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < HIST_BINS; i++) hist_q[i] <= '0;
      hist_cnt_q <= '0;
    end else begin
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end

  assign hist_cnt_o = hist_cnt_q;
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^hist_sel_i;
  assign hist_cnt_o      = 32'd0;
`endif

  assign meas_busy_o     = busy_q;
  assign wr_ticks_o      = wr_ticks_q;
  assign wr_units_o      = wr_units_q;
  assign rd_ticks_o      = rd_ticks_q;
  assign rd_words_o      = rd_words_q;
  assign rd_req_amount_o = req_q;
  assign min_max_delay_o = {min_q, max_q};
  assign sum_delay_o     = sum_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_amm_perf_monitor.sv
// Directed bench for amm_perf_monitor: a bus model pushes expected burst latencies into a scoreboard
// queue as data beats are driven; the queue is drained and compared once the stats pipe has settled.
`timescale 1ns/1ps
module tb_amm_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdvalid = 1'b0, waitreq = 1'b0, read = 1'b0, write = 1'b0, start_test = 1'b0;
  logic [10:0] burstcount = '0;
  logic [7:0]  byteenable = '0;
  logic [2:0]  hist_sel = '0;
  logic        busy;
  logic [31:0] wr_ticks, wr_units, rd_ticks, rd_words, rd_req, sum_delay, min_max, hist_cnt;
  logic [1:0]  err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {int acc; int beats;} burst_t;
  burst_t outst[$];
  int     lat_q[$];
  int     m_min, m_max, m_sum, m_req, m_wr_ticks, m_wr_units, m_rd_ticks, m_rd_words;
  logic [1:0] m_err;

  amm_perf_monitor dut (
    .clk_i(clk), .rst_i(rst), .readdatavalid_i(rdvalid), .waitrequest_i(waitreq),
    .read_i(read), .write_i(write), .burstcount_i(burstcount), .byteenable_i(byteenable),
    .start_test_i(start_test), .meas_busy_o(busy), .wr_ticks_o(wr_ticks), .wr_units_o(wr_units),
    .rd_ticks_o(rd_ticks), .rd_words_o(rd_words), .rd_req_amount_o(rd_req),
    .min_max_delay_o(min_max), .sum_delay_o(sum_delay), .err_o(err),
    .hist_sel_i(hist_sel), .hist_cnt_o(hist_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic modelClear();
    m_min = 16'hFFFF; m_max = 0; m_sum = 0; m_req = 0;
    m_wr_ticks = 0; m_wr_units = 0; m_rd_ticks = 0; m_rd_words = 0;
    m_err = 2'b00;
    lat_q.delete();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of bus activity and advances the reference model alongside it.
  task automatic applyStimulus(input logic rd, input logic wr, input logic wt, input logic rdv,
                               input logic [10:0] bc, input logic [7:0] be, input logic st);
    bit     full, popped;
    int     lat;
    burst_t h;
    read = rd; write = wr; waitreq = wt; rdvalid = rdv;
    burstcount = bc; byteenable = be; start_test = st;
    full = (outst.size() >= 8);
    popped = 0;
    lat = 0;
    if (outst.size() != 0) m_rd_ticks++;
    if (wr) m_wr_ticks++;
    if (wr && !wt) m_wr_units += $countones(be);
    if (rdv) begin
      m_rd_words++;
      if (outst.size() == 0) m_err[1] = 1'b1;
      else begin
        h = outst[0];
        h.beats--;
        outst[0] = h;
        if (h.beats == 0) begin
          lat = cyc - h.acc;
          popped = 1;
          void'(outst.pop_front());
        end
      end
    end
    if (rd && !wt) begin
      if (full) m_err[0] = 1'b1;
      else begin
        h.acc = cyc;
        h.beats = int'(bc);
        outst.push_back(h);
      end
    end
    if (st) modelClear();
    if (popped) lat_q.push_back(lat);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 11'd0, 8'h00, 0);
  endtask

  task automatic rdReq(input logic [10:0] bc);
    applyStimulus(1, 0, 0, 0, bc, 8'h00, 0);
  endtask

  task automatic beat();
    applyStimulus(0, 0, 0, 1, 11'd0, 8'h00, 0);
  endtask

  task automatic doStart();
    applyStimulus(0, 0, 0, 0, 11'd0, 8'h00, 1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    read = 0; write = 0; waitreq = 0; rdvalid = 0; start_test = 0;
    tick();
    tick();
    rst = 1'b0;
    outst.delete();
    modelClear();
  endtask

  // Drains the scoreboard queue into the running statistics, then compares every counter.
  task automatic checkAll(input string tag);
    int l;
    while (lat_q.size() != 0) begin
      l = lat_q.pop_front();
      if (l < m_min) m_min = l;
      if (l > m_max) m_max = l;
      m_sum += l;
      m_req++;
    end
    checkOutput({tag, ".min_max"}, min_max, {16'(m_min), 16'(m_max)});
    checkOutput({tag, ".sum"}, sum_delay, 32'(m_sum));
    checkOutput({tag, ".rd_req"}, rd_req, 32'(m_req));
    checkOutput({tag, ".rd_words"}, rd_words, 32'(m_rd_words));
    checkOutput({tag, ".rd_ticks"}, rd_ticks, 32'(m_rd_ticks));
    checkOutput({tag, ".wr_ticks"}, wr_ticks, 32'(m_wr_ticks));
    checkOutput({tag, ".wr_units"}, wr_units, 32'(m_wr_units));
    checkOutput({tag, ".err"}, err, m_err);
  endtask

  initial begin
    modelClear();
    doReset();
    $display("[TB] reset values");
    checkOutput("rst.min_max", min_max, 32'hFFFF_0000);
    checkOutput("rst.busy", busy, 1'b0);
    checkAll("rst");

    $display("[TB] single burst-4 read");
    rdReq(11'd4);
    idle(4);
    for (int i = 0; i < 4; i++) beat();
    idle(3);
    checkOutput("t1.min_max", min_max, {16'd8, 16'd8});
    checkOutput("t1.sum", sum_delay, 32'd8);
    checkOutput("t1.rd_words", rd_words, 32'd4);
    checkOutput("t1.rd_req", rd_req, 32'd1);
    checkOutput("t1.rd_ticks", rd_ticks, 32'd8);
    checkAll("t1");

    $display("[TB] eight back-to-back single reads");
    doStart();
    for (int t = 0; t < 18; t++)
      applyStimulus(t < 8, 0, 0, (t >= 3) && (t % 2 == 1), 11'd1, 8'h00, 0);
    checkOutput("t2.busy_pipe", busy, 1'b1);
    idle(1);
    checkOutput("t2.min_max", min_max, {16'd3, 16'd10});
    checkOutput("t2.sum", sum_delay, 32'd52);
    checkOutput("t2.busy_last", busy, 1'b1);
    checkAll("t2");
    idle(1);
    checkOutput("t2.busy_drop", busy, 1'b0);

    $display("[TB] tracker overflow and unsolicited data");
    doStart();
    for (int i = 0; i < 9; i++) rdReq(11'd1);
    idle(1);
    checkOutput("t3.err_ovf", err, 2'b01);
    for (int i = 0; i < 8; i++) beat();
    idle(3);
    checkOutput("t3.rd_req", rd_req, 32'd8);
    checkOutput("t3.busy", busy, 1'b0);
    beat();
    idle(1);
    checkOutput("t3.err_both", err, 2'b11);
    checkAll("t3");

    $display("[TB] byte-mode writes with a stall");
    doStart();
    applyStimulus(0, 1, 0, 0, 11'd0, 8'hFF, 0);
    applyStimulus(0, 1, 1, 0, 11'd0, 8'h0F, 0);
    applyStimulus(0, 1, 0, 0, 11'd0, 8'h0F, 0);
    applyStimulus(0, 1, 0, 0, 11'd0, 8'h01, 0);
    idle(2);
    checkOutput("t4.wr_units", wr_units, 32'd13);
    checkOutput("t4.wr_ticks", wr_ticks, 32'd4);
    checkAll("t4");

    $display("[TB] start_test against a stats update");
    doStart();
    rdReq(11'd1);
    rdReq(11'd2);
    beat();
    doStart();
    checkOutput("t5.min_max_clr", min_max, 32'hFFFF_0000);
    checkOutput("t5.sum_clr", sum_delay, 32'd0);
    checkOutput("t5.req_clr", rd_req, 32'd0);
    idle(1);
    beat();
    beat();
    idle(3);
    checkOutput("t5.min_max", min_max, {16'd5, 16'd5});
    checkOutput("t5.sum", sum_delay, 32'd5);
    checkAll("t5");

    $display("[TB] latencies 2, 5, 40");
    doStart();
    rdReq(11'd1); idle(1);  beat();
    rdReq(11'd1); idle(4);  beat();
    rdReq(11'd1); idle(39); beat();
    idle(3);
    checkOutput("t6.min_max", min_max, {16'd2, 16'd40});
    checkOutput("t6.sum", sum_delay, 32'd47);
    checkAll("t6");
`ifdef MEAS_HISTOGRAM_EN
    hist_sel = 3'd0; idle(1); checkOutput("t6.bin0", hist_cnt, 32'd1);
    hist_sel = 3'd1; idle(1); checkOutput("t6.bin1", hist_cnt, 32'd1);
    hist_sel = 3'd7; idle(1); checkOutput("t6.bin7", hist_cnt, 32'd1);
    hist_sel = 3'd2; idle(1); checkOutput("t6.bin2", hist_cnt, 32'd0);
`else
    hist_sel = 3'd0; idle(1); checkOutput("t6.hist_off0", hist_cnt, 32'd0);
    hist_sel = 3'd7; idle(1); checkOutput("t6.hist_off7", hist_cnt, 32'd0);
`endif

    $display("[TB] reset mid-burst");
    applyStimulus(0, 1, 0, 0, 11'd0, 8'h3C, 0);
    rdReq(11'd4);
    idle(2);
    beat();
    rst = 1'b1;
    rdvalid = 1'b0;
    tick();
    checkOutput("t7.min_max", min_max, 32'hFFFF_0000);
    checkOutput("t7.sum", sum_delay, 32'd0);
    checkOutput("t7.rd_words", rd_words, 32'd0);
    checkOutput("t7.wr_units", wr_units, 32'd0);
    checkOutput("t7.err", err, 2'b00);
    checkOutput("t7.busy", busy, 1'b0);
    checkOutput("t7.hist", hist_cnt, 32'd0);
    rst = 1'b0;
    outst.delete();
    modelClear();
    idle(3);
    checkAll("t7.after");
    checkOutput("t7.busy_after", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
